// File: rtl/sram_like_responder.sv
// sram_like_responder: memory-side responder for an SRAM-like req/addr_ok/data_ok bus.
// Requests are accepted in order. Writes commit to the word RAM when they are accepted,
// and reads sample the RAM at the same point. Each accepted request is queued with a
// countdown, so its response comes back in order and no earlier than LATENCY cycles later.
module sram_like_responder #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       wr,
  input  logic [1:0]                 size,
  input  logic [3:0]                 wstrb,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic                       addr_ok,
  output logic [31:0]                rdata,
  output logic                       data_ok,
  input  logic                       stall_addr,
  input  logic                       stall_data,
  output logic [$clog2(DEPTH):0]     outstanding
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]       mem    [2**ADDR_W];
  logic [31:0]       q_data [DEPTH];
  logic [3:0]        q_cnt  [DEPTH];
  logic [DEPTH-1:0]  q_wr;
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] idx;
  logic              full, empty, push, pop;

  // size is informational and the byte offset/upper address bits alias onto the same word.
  logic unused_ok;
  assign unused_ok = &{1'b0, size, addr[31:ADDR_W+2], addr[1:0]};

  assign idx         = addr[ADDR_W+1:2];
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign outstanding = count;

  // No pass-through: a full queue refuses the push even if the head pops this cycle.
  assign addr_ok = !reset && !full && !stall_addr;
  assign push    = req && addr_ok;
  assign data_ok = !reset && !empty && (q_cnt[head] == 4'd0) && !stall_data;
  assign pop     = data_ok;
  assign rdata   = (data_ok && !q_wr[head]) ? q_data[head] : 32'd0;

  // Word RAM: byte-masked write on accept. It is never cleared, so contents survive reset.
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Response queue: the countdown starts at LATENCY-1 so the head reaches 0 exactly
  // LATENCY cycles after accept. The read word is captured at accept time.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_cnt[i] != 4'd0) q_cnt[i] <= q_cnt[i] - 4'd1;
      end
      if (push) begin
        q_data[tail] <= mem[idx];
        q_wr[tail]   <= wr;
        q_cnt[tail]  <= 4'(LATENCY - 1);
        tail         <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder. A negedge monitor keeps a scoreboard of accepted requests
// and checks every response against a reference memory model. The scenario tasks drive
// stimulus and check timing and corner cases inline.
module tb_sram_like_responder;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;

  logic        clk = 0;
  logic        reset = 1;
  logic        req = 0;
  logic        wr = 0;
  logic [1:0]  size = 2'd2;
  logic [3:0]  wstrb = 0;
  logic [31:0] addr = 0;
  logic [31:0] wdata = 0;
  logic        stall_addr = 0;
  logic        stall_data = 0;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [$clog2(DEPTH):0] outstanding;

  sram_like_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .rdata(rdata), .data_ok(data_ok),
    .stall_addr(stall_addr), .stall_data(stall_data), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        wr;
    bit [31:0] data;
    bit        known;
    int        acc;
  } exp_t;

  exp_t        sb[$];
  bit [31:0]   mdl [int];
  int          acc_log[$];
  int          pop_log[$];
  bit [31:0]   rd_log[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: predicts addr_ok/data_ok/outstanding and checks every response.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_aok, exp_dok;
    bit [31:0] w;
    int   ix;
    if (reset) begin
      checks++;
      if ({addr_ok, data_ok, rdata} !== 34'd0) begin
        errors++;
        $display("FAIL reset_outputs: addr_ok=%0b data_ok=%0b rdata=%h, want all 0", addr_ok, data_ok, rdata);
      end
      sb.delete();
    end else begin
      checks++;
      if (outstanding !== sb.size()) begin
        errors++;
        $display("FAIL outstanding: got %0d want %0d at cyc %0d", outstanding, sb.size(), cyc);
      end
      exp_aok = (sb.size() < DEPTH) && !stall_addr;
      checks++;
      if (addr_ok !== exp_aok) begin
        errors++;
        $display("FAIL addr_ok: got %0b want %0b at cyc %0d", addr_ok, exp_aok, cyc);
      end
      exp_dok = (sb.size() > 0) && !stall_data && (cyc - sb[0].acc >= LATENCY);
      checks++;
      if (data_ok !== exp_dok) begin
        errors++;
        $display("FAIL data_ok: got %0b want %0b at cyc %0d", data_ok, exp_dok, cyc);
      end
      if (data_ok === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        if (e.wr || e.known) begin
          checks++;
          if (rdata !== (e.wr ? 32'd0 : e.data)) begin
            errors++;
            $display("FAIL rdata: got %h want %h at cyc %0d", rdata, e.wr ? 32'd0 : e.data, cyc);
          end
        end
        pop_log.push_back(cyc);
        rd_log.push_back(rdata);
      end else if (data_ok !== 1'b1) begin
        checks++;
        if (rdata !== 32'd0) begin
          errors++;
          $display("FAIL rdata_idle: got %h want 0 at cyc %0d", rdata, cyc);
        end
      end
      if (req && addr_ok === 1'b1) begin
        ix = int'(addr[ADDR_W+1:2]);
        if (wr) begin
          w = mdl.exists(ix) ? mdl[ix] : 32'd0;
          for (int i = 0; i < 4; i++) if (wstrb[i]) w[8*i +: 8] = wdata[8*i +: 8];
          if (wstrb == 4'hF || mdl.exists(ix)) mdl[ix] = w;
          e = '{wr: 1'b1, data: 32'd0, known: 1'b1, acc: cyc};
        end else begin
          e = '{wr: 1'b0, data: mdl.exists(ix) ? mdl[ix] : 32'd0, known: mdl.exists(ix), acc: cyc};
        end
        sb.push_back(e);
        acc_log.push_back(cyc);
      end
    end
  end

  task automatic idle(input int n);
    req = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Hold a request until it is accepted; leaves req asserted so calls chain back to back.
  task automatic issue(input bit w, input bit [3:0] s, input bit [31:0] a, input bit [31:0] d);
    bit ok = 0;
    req = 1; wr = w; wstrb = s; addr = a; wdata = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); #1;
      ok = (addr_ok === 1'b1);
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL issue_timeout: addr %h never accepted", a);
    end
  endtask

  task automatic drain();
    bit done = 0;
    req = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk); #1;
      done = (sb.size() == 0);
      @(posedge clk); #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries still pending", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (5) begin
      @(negedge clk); #1;
      checks++;
      if (addr_ok !== 1'b1 || data_ok !== 1'b0 || outstanding !== 0) begin
        errors++;
        $display("FAIL post_reset_idle: addr_ok=%0b data_ok=%0b outstanding=%0d, want 1/0/0", addr_ok, data_ok, outstanding);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_raw();
    int n0 = pop_log.size();
    int a0 = acc_log.size();
    int t0;
    issue(1, 4'hF, 32'h1C0, 32'hDEADBEEF);
    issue(0, 4'h0, 32'h1C0, 32'h0);
    idle(6);
    t0 = acc_log[a0];
    checks++;
    if (acc_log.size() != a0 + 2 || acc_log[a0+1] != t0 + 1) begin
      errors++;
      $display("FAIL raw_accept: accepts=%0d, want 2 on consecutive cycles", acc_log.size() - a0);
    end
    checks++;
    if (pop_log.size() != n0 + 2) begin
      errors++;
      $display("FAIL raw_pops: got %0d responses want 2", pop_log.size() - n0);
    end else begin
      checks++;
      if (pop_log[n0] != t0 + 2 || rd_log[n0] !== 32'd0) begin
        errors++;
        $display("FAIL raw_write_resp: cyc %0d rdata %h, want cyc %0d rdata 0", pop_log[n0], rd_log[n0], t0 + 2);
      end
      checks++;
      if (pop_log[n0+1] != t0 + 3 || rd_log[n0+1] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL raw_read_resp: cyc %0d rdata %h, want cyc %0d rdata deadbeef", pop_log[n0+1], rd_log[n0+1], t0 + 3);
      end
    end
  endtask

  task automatic test_strobe();
    issue(1, 4'hF, 32'h100, 32'h11223344);
    issue(1, 4'b0010, 32'h100, 32'h0000AB00);
    issue(0, 4'h0, 32'h100, 32'h0);
    issue(0, 4'h0, 32'h102, 32'h0);
    drain();
    checks++;
    if (rd_log[$-1] !== 32'h1122AB44 || rd_log[$] !== 32'h1122AB44) begin
      errors++;
      $display("FAIL strobe_merge: got %h / %h want 1122ab44", rd_log[$-1], rd_log[$]);
    end
  endtask

  task automatic test_full();
    int n0, a5;
    stall_data = 1;
    for (int i = 0; i < 4; i++) issue(0, 4'h0, 32'h1C0, 32'h0);
    req = 1; addr = 32'h100;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (addr_ok !== 1'b0 || outstanding !== 4) begin
        errors++;
        $display("FAIL full_hold: addr_ok=%0b outstanding=%0d, want 0/4", addr_ok, outstanding);
      end
      @(posedge clk); #1;
    end
    n0 = pop_log.size();
    stall_data = 0;
    issue(0, 4'h0, 32'h100, 32'h0);
    issue(0, 4'h0, 32'h1C0, 32'h0);
    drain();
    a5 = acc_log[acc_log.size()-2];
    checks++;
    if (pop_log.size() < n0 + 4) begin
      errors++;
      $display("FAIL full_release: got %0d pops want >= 4", pop_log.size() - n0);
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (pop_log[n0+i] != pop_log[n0] + i) begin
          errors++;
          $display("FAIL full_burst: pop %0d at cyc %0d want %0d", i, pop_log[n0+i], pop_log[n0] + i);
        end
      end
      checks++;
      if (a5 <= pop_log[n0]) begin
        errors++;
        $display("FAIL no_passthrough: 5th accept at cyc %0d, first pop at %0d", a5, pop_log[n0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    stall_data = 1;
    for (int i = 0; i < 3; i++) issue(0, 4'h0, 32'h100, 32'h0);
    req = 0;
    @(negedge clk); #1;
    checks++;
    if (outstanding !== 3) begin
      errors++;
      $display("FAIL pre_reset_outstanding: got %0d want 3", outstanding);
    end
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    stall_data = 0;
    n0 = pop_log.size();
    idle(5);
    @(negedge clk); #1;
    checks++;
    if (pop_log.size() != n0 || outstanding !== 0) begin
      errors++;
      $display("FAIL reset_drop: pops %0d outstanding %0d, want 0/0", pop_log.size() - n0, outstanding);
    end
    @(posedge clk); #1;
    issue(0, 4'h0, 32'h1C0, 32'h0);
    drain();
    checks++;
    if (pop_log.size() != n0 + 1 || rd_log[$] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reset_keeps_ram: rdata %h want deadbeef", rd_log[$]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) issue(1, 4'hF, 32'h200 + 32'(i*4), $urandom());
    for (int n = 0; n < 10000; n++) begin
      req        = ($urandom_range(0, 99) < 60);
      wr         = $urandom_range(0, 1);
      wstrb      = 4'($urandom_range(0, 15));
      addr       = {20'($urandom()), 7'h10, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      wdata      = $urandom();
      stall_addr = ($urandom_range(0, 99) < 20);
      stall_data = ($urandom_range(0, 99) < 30);
      @(posedge clk); #1;
    end
    stall_addr = 0;
    stall_data = 0;
    drain();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_strobe();
    test_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
